// File: rtl/ramio_bram.sv
// ramio_bram: the memory end of the RAMIO interface.
// It accepts byte, half-word and word requests over an enable/busy handshake and
// serves them from a word-organised synchronous block RAM with per-byte write
// enables. Read data is zero- or sign-extended and is flagged by a one-cycle
// data_out_ready pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high (RAM contents are kept)
//   enable         request valid; sampled only while idle and not busy
//   write_type     00 none, 01 byte, 10 half, 11 word
//   read_type      [1:0] size as write_type, [2] 1 = sign-extend, 0 = zero-extend
//   address        byte address; upper bits wrap modulo 4*DEPTH_WORDS
//   data_in        right-aligned write data
//   data_out       extended read result, held until the next read completes
//   data_out_ready one-cycle pulse when data_out has been updated
//   busy           high while a request is in progress
module ramio_bram #(
  parameter int unsigned ADDRESS_BITWIDTH = 32,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS      = 1024,
  parameter string       INIT_FILE        = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  write_type,
  input  logic [2:0]                  read_type,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_out_ready,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StReadOut} state_e;

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    latch;

  // Request fields captured at the accepting edge.
  logic [IdxW-1:0]         idx_q;
  logic [1:0]              lane_q;
  logic [1:0]              wtype_q;
  logic [2:0]              rtype_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0]   rd_word_q;
  logic [3:0]              mem_we;
  logic [3:0]              byte_en;
  logic [DATA_WIDTH-1:0]   wdata_rep;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   rd_ext;

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^address[ADDRESS_BITWIDTH-1:IdxW+2];

  // Lane enables and lane-replicated write data.
  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = wdata_q;
    unique case (wtype_q)
      2'b01: begin
        byte_en   = 4'b0001 << lane_q;
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b10: begin
        byte_en   = lane_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Lane extraction and extension of the registered RAM word.
  always_comb begin
    byte_sel = rd_word_q[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    unique case (rtype_q[1:0])
      2'b01:   rd_ext = {{24{rtype_q[2] & byte_sel[7]}}, byte_sel};
      2'b10:   rd_ext = {{16{rtype_q[2] & half_sel[15]}}, half_sel};
      default: rd_ext = rd_word_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    dout_d  = dout_q;
    mem_we  = 4'b0000;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !busy_q) begin
          // Writes win when both types are requested; the read is dropped.
          if (write_type != 2'b00) begin
            state_d = StWrite;
            busy_d  = 1'b1;
            latch   = 1'b1;
          end else if (read_type[1:0] != 2'b00) begin
            state_d = StRead;
            busy_d  = 1'b1;
            latch   = 1'b1;
          end
        end
      end
      StWrite: begin
        mem_we  = byte_en;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StRead: begin
        state_d = StReadOut;
      end
      StReadOut: begin
        dout_d  = rd_ext;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      idx_q   <= address[IdxW+1:2];
      lane_q  <= address[1:0];
      wtype_q <= write_type;
      rtype_q <= read_type;
      wdata_q <= data_in;
    end
  end

  // Single-port RAM with byte enables; no reset on the array. A reset that
  // coincides with the write cycle suppresses the write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i] && !rst) begin
        mem[idx_q][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
    if (state_q == StRead) begin
      rd_word_q <= mem[idx_q];
    end
  end

  assign data_out       = dout_q;
  assign data_out_ready = ready_q;
  assign busy           = busy_q;

endmodule
